vga_fifo_reader: RTL
====================

VGA_FIFO_READER -- requirements
Module: vga_fifo_reader

Interface
REQ-001 Parameter H_ACTIVE, default 1280, visible pixels per line.
REQ-002 Parameter H_FRONT/H_SYNC/H_BACK, defaults 48/112/248 (H_TOTAL = 1688).
REQ-003 Parameter V_ACTIVE, default 1024, visible lines per frame.
REQ-004 Parameter V_FRONT/V_SYNC/V_BACK, defaults 1/3/38 (V_TOTAL = 1066).
REQ-005 Parameter REQ_LEN, default 4, load-request pulse length in cycles.
REQ-006 One clock; reset is asynchronous and active-low: iCLK in 1, pixel clock; iRST_N in 1, asynchronous active-low reset.
REQ-007 iRDATA in 8, FIFO read data, valid one cycle after oREN.
REQ-008 iREMPTY in 1, FIFO empty flag.
REQ-009 oREN out 1, FIFO read enable.
REQ-010 oVGA_LINE_TO_LOAD out 13, line index the loader must fetch next.
REQ-011 oVGA_LOAD_TO_FIFO_REQ out 1, load-request pulse to the loader.
REQ-012 oPIXEL out 8, pixel intensity; oPIXEL_VALID out 1, active-video qualifier.
REQ-013 oHSYNC out 1, oVSYNC out 1, active-high syncs; oUNDERFLOW out 1, sticky per-frame error flag.

Function
REQ-014 h_count SHALL count 0..H_TOTAL-1 and wrap to 0; v_count SHALL increment when h_count wraps and SHALL itself wrap to 0 after V_TOTAL-1.
REQ-015 Active region SHALL be h_count < H_ACTIVE and v_count < V_ACTIVE; oREN SHALL equal the active predicate (combinational from counter registers).
REQ-016 oPIXEL SHALL be registered from iRDATA; oPIXEL_VALID, oHSYNC and oVSYNC SHALL be delayed two cycles from the counter state so all four align.
REQ-017 Raw hsync SHALL be high for H_ACTIVE+H_FRONT <= h_count < H_ACTIVE+H_FRONT+H_SYNC; raw vsync analogously on v_count.
REQ-018 next_line = (v_count == V_TOTAL-1) ? 0 : v_count+1.
REQ-019 At h_count == H_ACTIVE with next_line < V_ACTIVE, oVGA_LINE_TO_LOAD SHALL latch next_line and oVGA_LOAD_TO_FIFO_REQ SHALL be high for exactly REQ_LEN cycles, then low.
REQ-020 oVGA_LINE_TO_LOAD SHALL hold its value until the next request; no request SHALL issue for next_line >= V_ACTIVE.
REQ-021 States: IDLE -> REQ (at trigger) -> IDLE after REQ_LEN cycles; a trigger while in REQ cannot occur because REQ_LEN < H_TOTAL-H_ACTIVE.
REQ-022 If oREN and iREMPTY in the same cycle, the corresponding oPIXEL slot SHALL be 8'h00 and oUNDERFLOW SHALL set.
REQ-023 oUNDERFLOW SHALL clear when h_count == 0 and v_count == 0; a set in that same cycle SHALL win.
REQ-024 oPIXEL SHALL be 8'h00 whenever oPIXEL_VALID is low.

Reset
REQ-025 On iRST_N low: h_count = 0, v_count = V_TOTAL-1, state IDLE, all outputs 0 (oVGA_LINE_TO_LOAD = 0), both delay pipelines cleared.
REQ-026 Reset starting at v_count = V_TOTAL-1 SHALL make the first request (line 0) precede the first active line.
REQ-027 Reset mid-request SHALL drop the pulse immediately; FIFO flushing is not this block's duty.

Configuration
REQ-028 Macro VGA_TEST_PATTERN_EN: when defined, input iTEST_PATTERN (1 bit) exists; while high, oREN = 0, underflow detection is disabled, and the active oPIXEL = h_count[7:0] XOR v_count[7:0] (pipelined identically). Requests still issue.
REQ-029 Without VGA_TEST_PATTERN_EN the port and logic SHALL be absent.

Verification
REQ-030 Reset release, FIFO model non-empty -> request pulse 4 cycles at first h_count=1280, oVGA_LINE_TO_LOAD=0; first oREN at h=0,v=0.
REQ-031 Full frame with model FIFO -> 1024 requests, lines 0..1023 in order; oREN high exactly 1280x1024 cycles; oUNDERFLOW stays 0.
REQ-032 Feed iRDATA = 8'h5A -> oPIXEL = 8'h5A two cycles after oREN, coincident with oPIXEL_VALID=1.
REQ-033 Force iREMPTY=1 at pixel (10,5) -> that oPIXEL = 0, oUNDERFLOW=1 until next frame start, then 0.
REQ-034 Sync check -> oHSYNC high for 112 cycles per 1688-cycle line; oVSYNC high for 3 lines of 1066.
REQ-035 With VGA_TEST_PATTERN_EN and iTEST_PATTERN=1 -> oREN never high; pixel (3,1) = 8'h02.

Source files
------------

// File: rtl/vga_fifo_reader_if.sv
// Pixel-side bundle between the VGA FIFO reader (master) and its FIFO/loader/display environment (slave).
// iTEST_PATTERN exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_fifo_reader_if;
    logic [7:0]  iRDATA;
    logic        iREMPTY;
    logic        oREN;
    logic [12:0] oVGA_LINE_TO_LOAD;
    logic        oVGA_LOAD_TO_FIFO_REQ;
    logic [7:0]  oPIXEL;
    logic        oPIXEL_VALID;
    logic        oHSYNC;
    logic        oVSYNC;
    logic        oUNDERFLOW;
`ifdef VGA_TEST_PATTERN_EN
    logic        iTEST_PATTERN;

    modport master (
        input  iRDATA, iREMPTY, iTEST_PATTERN,
        output oREN, oVGA_LINE_TO_LOAD, oVGA_LOAD_TO_FIFO_REQ,
               oPIXEL, oPIXEL_VALID, oHSYNC, oVSYNC, oUNDERFLOW
    );
    modport slave (
        output iRDATA, iREMPTY, iTEST_PATTERN,
        input  oREN, oVGA_LINE_TO_LOAD, oVGA_LOAD_TO_FIFO_REQ,
               oPIXEL, oPIXEL_VALID, oHSYNC, oVSYNC, oUNDERFLOW
    );
`else
    modport master (
        input  iRDATA, iREMPTY,
        output oREN, oVGA_LINE_TO_LOAD, oVGA_LOAD_TO_FIFO_REQ,
               oPIXEL, oPIXEL_VALID, oHSYNC, oVSYNC, oUNDERFLOW
    );
    modport slave (
        output iRDATA, iREMPTY,
        input  oREN, oVGA_LINE_TO_LOAD, oVGA_LOAD_TO_FIFO_REQ,
               oPIXEL, oPIXEL_VALID, oHSYNC, oVSYNC, oUNDERFLOW
    );
`endif
endinterface

// File: rtl/vga_fifo_reader.sv
// VGA timing generator reading pixels from a line FIFO and requesting the next line from a loader; optional VGA_TEST_PATTERN_EN.
// Pixel/valid/syncs emerge 2 cycles after the counter state; no backpressure, an empty FIFO yields black and a sticky underflow flag.
module vga_fifo_reader #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FRONT  = 48,
    parameter int H_SYNC   = 112,
    parameter int H_BACK   = 248,
    parameter int V_ACTIVE = 1024,
    parameter int V_FRONT  = 1,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 38,
    parameter int REQ_LEN  = 4
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    vga_fifo_reader_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [12:0] H_ACT  = 13'(H_ACTIVE);
    localparam logic [12:0] H_LAST = 13'(H_TOTAL - 1);
    localparam logic [12:0] H_TRIG = 13'(H_ACTIVE - 1);
    localparam logic [12:0] HS_BEG = 13'(H_ACTIVE + H_FRONT);
    localparam logic [12:0] HS_END = 13'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [12:0] V_ACT  = 13'(V_ACTIVE);
    localparam logic [12:0] V_LAST = 13'(V_TOTAL - 1);
    localparam logic [12:0] VS_BEG = 13'(V_ACTIVE + V_FRONT);
    localparam logic [12:0] VS_END = 13'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam int CW = (REQ_LEN > 1) ? $clog2(REQ_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REQ_LEN - 1);

    typedef enum logic {IDLE, REQ} state_t;

    state_t        state;
    logic [CW-1:0] req_cnt;
    logic [12:0]   h_count, v_count, next_line, line_q;
    logic          req_q, active, hs_raw, vs_raw, rd_en, under_det;
    logic          vld1, hs1, vs1, emp1, vld2, hs2, vs2, underflow_q;
    logic [7:0]    pix_q, pix_nxt;

    always_comb begin
        active    = (h_count < H_ACT) && (v_count < V_ACT);
        hs_raw    = (h_count >= HS_BEG) && (h_count < HS_END);
        vs_raw    = (v_count >= VS_BEG) && (v_count < VS_END);
        next_line = (v_count == V_LAST) ? 13'd0 : v_count + 13'd1;
    end

`ifdef VGA_TEST_PATTERN_EN
    logic       tp1;
    logic [7:0] pat1;

    assign rd_en = active & ~bus.iTEST_PATTERN;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            tp1  <= 1'b0;
            pat1 <= 8'h00;
        end else begin
            tp1  <= bus.iTEST_PATTERN;
            pat1 <= h_count[7:0] ^ v_count[7:0];
        end
    end

    always_comb begin
        pix_nxt = 8'h00;
        if (vld1) begin
            if (tp1)       pix_nxt = pat1;
            else if (!emp1) pix_nxt = bus.iRDATA;
        end
    end
`else
    assign rd_en = active;

    always_comb begin
        pix_nxt = 8'h00;
        if (vld1 && !emp1) pix_nxt = bus.iRDATA;
    end
`endif

    assign under_det = rd_en & bus.iREMPTY;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            h_count <= 13'd0;
            v_count <= V_LAST;
        end else if (h_count == H_LAST) begin
            h_count <= 13'd0;
            v_count <= (v_count == V_LAST) ? 13'd0 : v_count + 13'd1;
        end else begin
            h_count <= h_count + 13'd1;
        end
    end

    // Stage 1 tags the FIFO read slot; stage 2 forms the pixel from read data arriving a cycle later.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            vld1 <= 1'b0; hs1 <= 1'b0; vs1 <= 1'b0; emp1 <= 1'b0;
            vld2 <= 1'b0; hs2 <= 1'b0; vs2 <= 1'b0; pix_q <= 8'h00;
            underflow_q <= 1'b0;
        end else begin
            vld1  <= active;
            hs1   <= hs_raw;
            vs1   <= vs_raw;
            emp1  <= under_det;
            vld2  <= vld1;
            hs2   <= hs1;
            vs2   <= vs1;
            pix_q <= pix_nxt;
            if (under_det)
                underflow_q <= 1'b1;
            else if (h_count == 13'd0 && v_count == 13'd0)
                underflow_q <= 1'b0;
        end
    end

    // Trigger one cycle early so the registered pulse starts exactly at h_count == H_ACTIVE.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state   <= IDLE;
            req_cnt <= '0;
            req_q   <= 1'b0;
            line_q  <= 13'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (h_count == H_TRIG && next_line < V_ACT) begin
                        state   <= REQ;
                        req_cnt <= '0;
                        req_q   <= 1'b1;
                        line_q  <= next_line;
                    end
                end
                REQ: begin
                    if (req_cnt == CNT_LAST) begin
                        state <= IDLE;
                        req_q <= 1'b0;
                    end else begin
                        req_cnt <= req_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.oREN                  = rd_en;
    assign bus.oVGA_LINE_TO_LOAD     = line_q;
    assign bus.oVGA_LOAD_TO_FIFO_REQ = req_q;
    assign bus.oPIXEL                = pix_q;
    assign bus.oPIXEL_VALID          = vld2;
    assign bus.oHSYNC                = hs2;
    assign bus.oVSYNC                = vs2;
    assign bus.oUNDERFLOW            = underflow_q;
endmodule
